wb_dest_decoder_5bit: RTL and testbench

//  Write-back destination decoder/scoreboard for the 32-entry register file.

---
 rtl/wb_dest_decoder_5bit_pkg.sv | 11 +
 rtl/wb_dest_decoder_5bit_decoder_5to32.sv | 15 +
 rtl/wb_dest_decoder_5bit.sv | 84 ++++++++
 tb/tb_wb_dest_decoder_5bit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_dest_decoder_5bit_pkg.sv
// rtl/wb_dest_decoder_5bit_pkg.sv - shared sizes and constants for the write-back destination decoder
package wb_dest_decoder_5bit_pkg;

  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;
  localparam int CNT_W  = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

endpackage

// File: rtl/wb_dest_decoder_5bit_decoder_5to32.sv
// rtl/wb_dest_decoder_5bit_decoder_5to32.sv - combinational register-number to one-hot decoder with enable
module decoder_5to32
  import wb_dest_decoder_5bit_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] sel,
  output logic [NREG-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/wb_dest_decoder_5bit.sv
// rtl/wb_dest_decoder_5bit.sv - write-back one-hot decoder with per-register in-flight scoreboard
module wb_dest_decoder_5bit
  import wb_dest_decoder_5bit_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic [NREG-1:0]   wr_onehot,
  input  logic [ADDR_W-1:0] rs_a,
  input  logic [ADDR_W-1:0] rs_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [NREG-1:0]   pending,
  output logic              err_underflow
);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  iss_oh;
  logic [NREG-1:0]  wb_oh;
  logic [NREG-1:0]  wr_next;
  logic             underflow;
  logic             issue_en;
  logic             wb_en;

  // Saturation is judged on registered state only; a same-cycle write-back does not bypass it.
  assign issue_ready = (issue_rd == REG_ZERO) || (cnt[issue_rd] != CNT_MAX);
  assign issue_en    = issue_valid && issue_ready && (issue_rd != REG_ZERO);
  assign wb_en       = wb_valid && (wb_rd != REG_ZERO);

  decoder_5to32 u_issue_dec (
    .en     (issue_en),
    .sel    (issue_rd),
    .onehot (iss_oh)
  );

  decoder_5to32 u_wb_dec (
    .en     (wb_en),
    .sel    (wb_rd),
    .onehot (wb_oh)
  );

  always_comb begin
    pending = '0;
    for (int r = 1; r < NREG; r++) pending[r] = (cnt[r] != '0);
  end

  assign hazard_a = pending[rs_a];
  assign hazard_b = pending[rs_b];

  // A write-back to an idle register is legal only when its issue lands in the same cycle.
  always_comb begin
    wr_next   = '0;
    underflow = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (wb_oh[r]) begin
        if (pending[r] || iss_oh[r]) wr_next[r] = 1'b1;
        else                         underflow  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      wr_onehot     <= '0;
      err_underflow <= 1'b0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (iss_oh[r] && !wb_oh[r])
          cnt[r] <= cnt[r] + 1'b1;
        else if (wb_oh[r] && !iss_oh[r] && pending[r])
          cnt[r] <= cnt[r] - 1'b1;
      end
      wr_onehot <= wr_next;
      if (underflow) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_dest_decoder_5bit.sv
// tb/tb_wb_dest_decoder_5bit.sv - self-checking bench for wb_dest_decoder_5bit
module tb_wb_dest_decoder_5bit;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wr_onehot;
  logic [4:0]  rs_a;
  logic [4:0]  rs_b;
  logic        hazard_a;
  logic        hazard_b;
  logic [31:0] pending;
  logic        err_underflow;

  int vectors;
  int miscompares;

  int          cnt_m [32];
  logic        err_m;
  logic [31:0] wr_m;

  wb_dest_decoder_5bit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wr_onehot     (wr_onehot),
    .rs_a          (rs_a),
    .rs_b          (rs_b),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b),
    .pending       (pending),
    .err_underflow (err_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend_m();
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < 32; r++) v[r] = (cnt_m[r] > 0);
    return v;
  endfunction

  function automatic logic ready_m(input logic [4:0] rd);
    return (rd == 5'd0) || (cnt_m[rd] < 3);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    err_m = 1'b0;
    wr_m  = '0;
  endtask

  // Called just after a falling edge; leaves the bench at the next falling edge.
  task automatic step(input logic iv, input logic [4:0] ird, input logic wv,
                      input logic [4:0] wrd, input logic [4:0] ra, input logic [4:0] rb);
    logic acc;
    logic wbo;
    logic dec;
    logic [31:0] pv;
    issue_valid = iv; issue_rd = ird;
    wb_valid = wv; wb_rd = wrd;
    rs_a = ra; rs_b = rb;
    #1;
    pv = pend_m();
    check("issue_ready", {31'b0, issue_ready}, {31'b0, ready_m(ird)});
    check("hazard_a", {31'b0, hazard_a}, {31'b0, pv[ra]});
    check("hazard_b", {31'b0, hazard_b}, {31'b0, pv[rb]});
    check("pending", pending, pv);
    acc = iv && (ird != 5'd0) && ready_m(ird);
    wbo = wv && (wrd != 5'd0);
    dec = wbo && (cnt_m[wrd] > 0 || (acc && ird == wrd));
    wr_m = '0;
    if (dec) wr_m = 32'd1 << wrd;
    else if (wbo) err_m = 1'b1;
    if (acc) cnt_m[ird] = cnt_m[ird] + 1;
    if (dec) cnt_m[wrd] = cnt_m[wrd] - 1;
    @(posedge clock);
    #1;
    check("wr_onehot", wr_onehot, wr_m);
    check("err_underflow", {31'b0, err_underflow}, {31'b0, err_m});
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0;
    rs_a = '0; rs_b = '0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("rst_wr_onehot", wr_onehot, 32'h0);
    check("rst_pending", pending, 32'h0);
    check("rst_issue_ready", {31'b0, issue_ready}, 32'h1);
    reset_n = 1'b1;
    @(negedge clock);

    // Issue then write-back on r7.
    step(1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    check("t2_wr_onehot", wr_onehot, 32'h0000_0080);
    step(1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 5'd7);
    check("t2_pending7_clear", {31'b0, pending[7]}, 32'h0);

    // Saturate r3, drop the 4th issue, then release one slot.
    step(1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 5'd0);
    step(1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 5'd0);
    step(1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 5'd0);
    step(1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd0);
    step(1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 5'd0);
    step(1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 5'd3);
    step(1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 5'd3);
    step(1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 5'd3);
    step(1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 5'd3);

    // Same-cycle issue and write-back on r9 with one outstanding.
    step(1'b1, 5'd9, 1'b0, 5'd0, 5'd9, 5'd0);
    step(1'b1, 5'd9, 1'b1, 5'd9, 5'd9, 5'd0);
    check("t4_wr_onehot", wr_onehot, 32'h0000_0200);
    check("t4_pending9", {31'b0, pending[9]}, 32'h1);
    step(1'b0, 5'd0, 1'b1, 5'd9, 5'd9, 5'd9);

    // Register 0 is never tracked.
    step(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    check("t6_wr_onehot", wr_onehot, 32'h0);
    check("t6_err", {31'b0, err_underflow}, 32'h0);
    idle();

    // Asynchronous reset with r5 outstanding twice.
    step(1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 5'd0);
    step(1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 5'd5);
    issue_valid = 1'b1; issue_rd = 5'd5; rs_a = 5'd5; rs_b = 5'd5;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_pending", pending, 32'h0);
    check("async_hazard_a", {31'b0, hazard_a}, 32'h0);
    check("async_hazard_b", {31'b0, hazard_b}, 32'h0);
    check("async_ready", {31'b0, issue_ready}, 32'h1);
    check("async_wr_onehot", wr_onehot, 32'h0);
    model_reset();
    issue_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle();

    // Underflow on r12 is sticky.
    step(1'b0, 5'd0, 1'b1, 5'd12, 5'd12, 5'd0);
    check("t5_wr_onehot", wr_onehot, 32'h0);
    check("t5_err", {31'b0, err_underflow}, 32'h1);
    idle();
    idle();
    check("t5_err_sticky", {31'b0, err_underflow}, 32'h1);

    // Same-cycle issue + write-back on idle register: no error.
    reset_n = 1'b0;
    @(negedge clock);
    model_reset();
    reset_n = 1'b1;
    step(1'b1, 5'd14, 1'b1, 5'd14, 5'd14, 5'd0);
    check("net0_wr_onehot", wr_onehot, 32'h0000_4000);
    check("net0_err", {31'b0, err_underflow}, 32'h0);

    // Random traffic over a small register window to force collisions.
    for (int i = 0; i < 400; i++) begin
      logic        iv, wv;
      logic [4:0]  ird, wrd, ra, rb;
      iv  = ($urandom_range(0, 99) < 60);
      wv  = ($urandom_range(0, 99) < 45);
      ird = 5'($urandom_range(0, 6));
      wrd = 5'($urandom_range(0, 6));
      ra  = 5'($urandom_range(0, 7));
      rb  = 5'($urandom_range(0, 31));
      if (i == 200) begin
        reset_n = 1'b0;
        @(negedge clock);
        model_reset();
        reset_n = 1'b1;
      end
      step(iv, ird, wv, wrd, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
